mem_arbiter: RTL

Shares one single-port memory between the instruction-fetch stage (read-only) and the data-access stage (read/write) of the CPU pipeline. It grants one requester at a time, drives the memory port, and returns read data and completion pulses. Data accesses have priority, with bounded starvation protection for fetch and a watchdog that aborts hung memory transactions. It sits between `instruction_fetch`/memory-stage logic and the shared instruction/data memory.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch (read-only) and data (read/write); grant is combinational in IDLE.
// Completion is one cycle after mem_ready (min 2 cycles req->valid); requests wait while busy; data has priority with streak-bounded fetch starvation and a watchdog abort.
module mem_arbiter #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_BURST);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);
    localparam bit         WD_EN      = (TIMEOUT != 0);

    state_t              state_q, state_d;
    logic [3:0]          streak_q, streak_d;
    logic [7:0]          wd_q, wd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                d_valid_q, d_valid_d;
    logic                err_q, err_d;
    logic                wd_expired;

    // Abort fires in the TIMEOUT-th busy cycle; the counter starts at 0 in the first one.
    assign wd_expired = WD_EN && (wd_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        wd_d       = wd_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !(if_req && (streak_q == MAX_STREAK))) begin
                    d_gnt   = 1'b1;
                    state_d = D_BUSY;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    wd_d    = 8'd0;
                    if (!if_req)
                        streak_d = 4'd0;
                    else if (streak_q != MAX_STREAK)
                        streak_d = streak_q + 4'd1;
                end else if (if_req) begin
                    if_gnt   = 1'b1;
                    state_d  = IF_BUSY;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wd_d     = 8'd0;
                    streak_d = 4'd0;
                end
            end
            IF_BUSY, D_BUSY: begin
                // A same-cycle mem_ready beats the watchdog.
                if (mem_ready || wd_expired) begin
                    state_d = IDLE;
                    err_d   = !mem_ready;
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if (mem_ready)
                            if_rdata_d = mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (mem_ready && !we_q)
                            d_rdata_d = mem_rdata;
                    end
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            streak_q   <= 4'd0;
            wd_q       <= 8'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            wd_q       <= wd_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
        end
    end

    assign mem_en    = (state_q != IDLE);
    assign mem_we    = (state_q == D_BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign err       = err_q;

endmodule
